calc_cmd_ctrl: RTL and testbench

CALC_CMD_CTRL -- requirements
Module: calc_cmd_ctrl

---
 rtl/calc_cmd_ctrl.sv | 155 +++++++++++++++
 tb/tb_calc_cmd_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_ctrl.sv
// calc_cmd_ctrl: receives a 3-byte command frame {0xA_op, a, b} from a UART
// receiver, drives an external ALU, and returns the result byte followed by
// the flag byte (or a single 0xEE for unsupported opcodes).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a header byte 0xA<op>
// GET_A  | header accepted, waiting for operand a (timeout armed)
// GET_B  | operand a latched, waiting for operand b (timeout armed)
// EXEC   | one cycle: capture ALU result and flag
// SEND_Y | offering captured result byte
// SEND_F | offering captured flag byte
// SEND_E | offering error code 0xEE for op > 7
module calc_cmd_ctrl #(
  parameter int N       = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_y,
  input  logic         alu_flg,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, EXEC, SEND_Y, SEND_F, SEND_E
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  // The gap expires on the cycle the counter would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [N-1:0]    y_q, y_d;
  logic            flg_q, flg_d;
  logic            err_q, err_d;
  logic            tx_hs;

  assign tx_hs = tx_valid && tx_ready;

  // Next-state logic: byte capture, timeout, overrun detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    y_d      = y_q;
    flg_d    = flg_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:4] == 4'hA) begin
            alu_op_d = rx_data[3:0];
            cnt_d    = '0;
            state_d  = GET_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_A, GET_B: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == GET_A) begin
            alu_a_d = rx_data;
            state_d = GET_B;
          end else begin
            alu_b_d = rx_data;
            state_d = EXEC;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXEC: begin
        y_d     = alu_y;
        flg_d   = alu_flg;
        err_d   = rx_valid;
        state_d = (alu_op_q <= 4'h7) ? SEND_Y : SEND_E;
      end
      SEND_Y: begin
        err_d = rx_valid;
        if (tx_hs) state_d = SEND_F;
      end
      SEND_F, SEND_E: begin
        // A byte arriving with the final handshake is still an overrun.
        err_d = rx_valid;
        if (tx_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit mux: tx_data only depends on state and captured registers,
  // so it is stable for the whole time a byte is offered.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      SEND_Y: begin tx_valid = 1'b1; tx_data = y_q;            end
      SEND_F: begin tx_valid = 1'b1; tx_data = {7'b0, flg_q}; end
      SEND_E: begin tx_valid = 1'b1; tx_data = 8'hEE;         end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      y_q      <= '0;
      flg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      y_q      <= y_d;
      flg_q    <= flg_d;
      err_q    <= err_d;
    end
  end

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign busy   = (state_q != IDLE);
  assign err    = err_q;

endmodule

// File: tb/tb_calc_cmd_ctrl.sv
// Bench for calc_cmd_ctrl: table of command frames plus hand sequences for
// backpressure, overrun, timeout and reset. Transmitted bytes are checked
// against a queue of expected bytes filled when a frame is driven.
module tb_calc_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_flg;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, err;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];

  calc_cmd_ctrl #(.N(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_flg(alu_flg), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference ALU attached to the controller.
  always_comb begin
    case (alu_op)
      4'h0: alu_y = alu_a + alu_b;
      4'h1: alu_y = alu_a - alu_b;
      4'h2: alu_y = alu_a & alu_b;
      4'h3: alu_y = alu_a | alu_b;
      4'h4: alu_y = alu_a ^ alu_b;
      4'h5: alu_y = alu_a << alu_b[2:0];
      4'h6: alu_y = alu_a >> alu_b[2:0];
      4'h7: alu_y = alu_a;
      default: alu_y = 8'h00;
    endcase
    alu_flg = (alu_a == alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmit monitor: a handshake will happen at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_seen++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      tick();
      n++;
    end
    chk(name, (n < 40), 1);
  endtask

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] a;
    logic [7:0] b;
    int         ntx;
    logic [7:0] tx0;
    logic [7:0] tx1;
  } frame_t;

  frame_t tbl[10];

  initial begin
    tbl[0] = '{8'hA0, 8'h05, 8'h03, 2, 8'h08, 8'h00};
    tbl[1] = '{8'hA1, 8'h07, 8'h07, 2, 8'h00, 8'h01};
    tbl[2] = '{8'hA5, 8'h03, 8'h02, 2, 8'h0C, 8'h00};
    tbl[3] = '{8'hA9, 8'h01, 8'h02, 1, 8'hEE, 8'h00};
    tbl[4] = '{8'hA4, 8'h0F, 8'h0F, 2, 8'h00, 8'h01};
    tbl[5] = '{8'hA3, 8'h50, 8'h0A, 2, 8'h5A, 8'h00};
    tbl[6] = '{8'hA6, 8'h80, 8'h03, 2, 8'h10, 8'h00};
    tbl[7] = '{8'hA7, 8'h33, 8'h44, 2, 8'h33, 8'h00};
    tbl[8] = '{8'hA8, 8'h33, 8'h44, 1, 8'hEE, 8'h00};
    tbl[9] = '{8'hAF, 8'hFF, 8'h01, 1, 8'hEE, 8'h00};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    #12;
    chk("rst_outs", {alu_op, alu_a, alu_b, tx_data}, 32'h0);
    chk("rst_flags", {tx_valid, busy, err}, 3'b000);
    @(negedge clk) rst = 1'b0;
    tick();

    // Table-driven frames with a ready transmitter.
    for (int i = 0; i < 10; i++) begin
      int eb = err_seen;
      exp_q.push_back(tbl[i].tx0);
      if (tbl[i].ntx == 2) exp_q.push_back(tbl[i].tx1);
      send_byte(tbl[i].hdr);
      send_byte(tbl[i].a);
      send_byte(tbl[i].b);
      wait_done($sformatf("frame%0d_done", i));
      chk($sformatf("frame%0d_ops", i), {alu_op, alu_a, alu_b}, {tbl[i].hdr[3:0], tbl[i].a, tbl[i].b});
      chk($sformatf("frame%0d_noerr", i), err_seen - eb, 0);
      chk($sformatf("frame%0d_txv", i), tx_valid, 1'b0);
    end

    // Bad header: dropped, err for one cycle, nothing sent.
    send_byte(8'h35);
    chk("badhdr_err", {err, busy}, 2'b10);
    tick();
    chk("badhdr_err_clr", {err, busy, tx_valid}, 3'b000);

    // Backpressure, latency, overrun during send and with final handshake.
    tx_ready = 1'b0;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h00);
    send_byte(8'hA2);
    send_byte(8'hF0);
    send_byte(8'h3C);
    chk("lat_exec_txv", tx_valid, 1'b0);
    tick();
    chk("lat_send_txv", tx_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {tx_valid, tx_data}, {1'b1, 8'h30});
      tick();
    end
    send_byte(8'h55);
    chk("overrun_err", {err, tx_valid, tx_data}, {1'b1, 1'b1, 8'h30});
    tx_ready = 1'b1;
    tick();
    chk("send_f", {tx_valid, tx_data}, {1'b1, 8'h00});
    send_byte(8'hA0);
    chk("final_hs_overrun", {err, busy, tx_valid}, 3'b100);
    tick();
    chk("final_hs_dropped", {err, busy}, 2'b00);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Inter-byte timeout: TIMEOUT=16 idle cycles in GET_A.
    send_byte(8'hA3);
    repeat (15) tick();
    chk("to_pending", {busy, err}, 2'b10);
    tick();
    chk("to_fire", {err, busy}, 2'b10);
    chk("to_keep_ops", {alu_op, alu_a, alu_b}, {4'h3, 8'hF0, 8'h3C});
    tick();
    chk("to_err_clr", err, 1'b0);

    // Reset during GET_B, then a clean frame.
    send_byte(8'hA0);
    send_byte(8'h01);
    chk("getb_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_getb_outs", {alu_op, alu_a, alu_b, tx_data, tx_valid, busy, err}, 31'h0);
    @(negedge clk) rst = 1'b0;
    tick();
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    send_byte(8'hA0);
    send_byte(8'h01);
    send_byte(8'h01);
    wait_done("post_rst_done");

    // Reset while a byte is offered: nothing re-offered afterwards.
    tx_ready = 1'b0;
    send_byte(8'hA0);
    send_byte(8'h02);
    send_byte(8'h02);
    tick();
    chk("midsend_txv", tx_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_send_outs", {tx_valid, tx_data, busy}, 10'h0);
    @(negedge clk) rst = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    chk("no_reoffer", {tx_valid, busy}, 2'b00);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
